// File: rtl/axi_stream_pkg.sv
// Shared AXI-stream beat types for the result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a; TREADY travels in its own struct opposite to the beat.
package axi_stream_pkg;

    localparam int AXIS_DATA_W = 64;

    // Master-to-slave half of a stream: the beat itself.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] TDATA;
        logic                   TVALID;
        logic                   TLAST;
    } axi_stream_mastero_slavei_t;

    // Slave-to-master half of a stream: the ready handshake.
    typedef struct packed {
        logic TREADY;
    } axi_stream_masteri_slaveo_t;

endpackage

// File: rtl/fifo_ram_dp.sv
// DEPTH x WIDTH register array, one synchronous write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller only asserts we when a slot is free.
module fifo_ram_dp #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; stale words are hidden by TVALID.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cubic_result_fifo.sv
// FWFT AXI-stream FIFO buffering evaluator results, with occupancy and frame count.
// Latency: beat pushed at edge N is presented on m_out after edge N (no bypass).
// Backpressure: s_out.TREADY = !full from registered state; never looks at m_in.TREADY.
module cubic_result_fifo
    import axi_stream_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  axi_stream_mastero_slavei_t s_in,
    output axi_stream_masteri_slaveo_t s_out,
    output axi_stream_mastero_slavei_t m_out,
    input  axi_stream_masteri_slaveo_t m_in,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                frames_out
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WORD_W = AXIS_DATA_W + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [15:0]       frames_q;
    logic              occ_full;
    logic              occ_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] rd_word;

    assign occ_full  = (count_q == CNT_W'(DEPTH));
    assign occ_empty = (count_q == '0);

    // Handshakes are forced low while rst is held so nothing moves during reset.
    assign s_out.TREADY = !rst && !occ_full;
    assign m_out.TVALID = !rst && !occ_empty;
    assign m_out.TDATA  = rd_word[AXIS_DATA_W-1:0];
    assign m_out.TLAST  = rd_word[AXIS_DATA_W];

    assign push = s_in.TVALID && s_out.TREADY;
    assign pop  = m_out.TVALID && m_in.TREADY;

    assign count      = count_q;
    assign full       = !rst && occ_full;
    assign empty      = rst || occ_empty;
    assign frames_out = frames_q;

    fifo_ram_dp #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_in.TLAST, s_in.TDATA}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // Pointers wrap naturally; count is kept separately so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Completed frames leaving downstream; wraps at 2^16 without saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
        end else if (pop && m_out.TLAST) begin
            frames_q <= frames_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_cubic_result_fifo.sv
module tb_cubic_result_fifo;
    import axi_stream_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    axi_stream_mastero_slavei_t s_in;
    axi_stream_masteri_slaveo_t s_out;
    axi_stream_mastero_slavei_t m_out;
    axi_stream_masteri_slaveo_t m_in;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic [15:0]                frames_out;

    cubic_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .s_out      (s_out),
        .m_out      (m_out),
        .m_in       (m_in),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .frames_out (frames_out)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: an ordered queue of {TLAST, TDATA} plus a 16-bit frame tally.
    logic [64:0] mq[$];
    logic [64:0] popped[$];
    logic [15:0] mframes;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic real horner(input real x);
        return ((1.0 * x + 2.0) * x + 3.5) * x + 4.5;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [63:0] d, input logic l, input logic rd);
        rst          = r;
        s_in.TVALID  = v;
        s_in.TDATA   = d;
        s_in.TLAST   = l;
        m_in.TREADY  = rd;
        #2;
    endtask

    task automatic model_check();
        logic r;
        logic tr;
        logic tv;
        r  = rst;
        tr = !r && (mq.size() < DEPTH);
        tv = !r && (mq.size() > 0);
        chk("tready", 64'(s_out.TREADY), 64'(tr));
        chk("tvalid", 64'(m_out.TVALID), 64'(tv));
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(!r && mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(r || mq.size() == 0));
        chk("frames", 64'(frames_out), 64'(mframes));
        if (tv) begin
            chk("tdata", m_out.TDATA, mq[0][63:0]);
            chk("tlast", 64'(m_out.TLAST), 64'(mq[0][64]));
        end
    endtask

    task automatic advance();
        logic        r;
        logic        mpush;
        logic        mpop;
        logic [64:0] e;
        r     = rst;
        mpush = s_in.TVALID && !r && (mq.size() < DEPTH);
        mpop  = m_in.TREADY && !r && (mq.size() > 0);
        e     = {s_in.TLAST, s_in.TDATA};
        @(posedge clk);
        if (r) begin
            mq.delete();
            mframes = 16'd0;
        end else begin
            if (mpop) begin
                popped.push_back(mq[0]);
                if (mq[0][64]) mframes = mframes + 16'd1;
                void'(mq.pop_front());
            end
            if (mpush) mq.push_back(e);
        end
        #1;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [63:0] d, input logic l,
                         input logic rd, input bit en);
        drive(r, v, d, l, rd);
        if (en) model_check();
        advance();
    endtask

    typedef struct {
        logic        rst;
        logic        vld;
        logic [63:0] dat;
        logic        last;
        logic        rdy;
        int          cnt;
        logic        tv;
        logic        tr;
        logic [63:0] edat;
        logic        elast;
        logic [15:0] frm;
    } vec_t;

    vec_t vt[13];
    real  xs[9];
    logic [63:0] vals[9];
    logic        lasts[9];
    logic [64:0] sent[$];

    initial begin
        // Reset hold, then push 27.5/TLAST into an always-ready consumer.
        for (int i = 0; i < 10; i++)
            vt[i] = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 64'd0, 1'b0, 16'd0};
        vt[10] = '{1'b0, 1'b1, $realtobits(27.5), 1'b1, 1'b1, 0, 1'b0, 1'b1, 64'd0, 1'b0, 16'd0};
        vt[11] = '{1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1, 1'b1, 1'b1, $realtobits(27.5), 1'b1, 16'd0};
        vt[12] = '{1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 64'd0, 1'b0, 16'd1};

        rst    = 1'b1;
        s_in   = '0;
        m_in   = '0;
        mframes = 16'd0;
        @(posedge clk);
        #1;
        mq.delete();

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst, vt[i].vld, vt[i].dat, vt[i].last, vt[i].rdy);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].cnt));
            chk($sformatf("vec%0d_tvalid", i), 64'(m_out.TVALID), 64'(vt[i].tv));
            chk($sformatf("vec%0d_tready", i), 64'(s_out.TREADY), 64'(vt[i].tr));
            chk($sformatf("vec%0d_frames", i), 64'(frames_out), 64'(vt[i].frm));
            if (vt[i].tv) begin
                chk($sformatf("vec%0d_tdata", i), m_out.TDATA, vt[i].edat);
                chk($sformatf("vec%0d_tlast", i), 64'(m_out.TLAST), 64'(vt[i].elast));
            end
            model_check();
            advance();
        end

        // Fill to full with a stalled consumer; the 9th beat waits for space.
        xs = '{2.0, 1.0, 10.0, -1.0, 0.0, 3.0, -2.0, 4.0, 5.0};
        for (int k = 0; k < 9; k++) begin
            vals[k]  = $realtobits(horner(xs[k]));
            lasts[k] = (k % 3 == 2);
        end
        popped.delete();
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, vals[k], lasts[k], 1'b0, 1'b1);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_tready", 64'(s_out.TREADY), 64'd0);
        chk("fill_count", 64'(count), 64'(DEPTH));
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, vals[8], lasts[8], 1'b0, 1'b1);
            chk("stall_head", m_out.TDATA, $realtobits(27.5));
        end
        chk("first_pop_tready", 64'(s_out.TREADY), 64'd0);
        cycle(1'b0, 1'b1, vals[8], lasts[8], 1'b1, 1'b1);
        chk("after_pop_tready", 64'(s_out.TREADY), 64'd1);
        chk("after_pop_count", 64'(count), 64'd7);
        cycle(1'b0, 1'b1, vals[8], lasts[8], 1'b1, 1'b1);
        chk("ninth_in_count", 64'(count), 64'd7);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("order_size", 64'(popped.size()), 64'd9);
        chk("order0", popped[0][63:0], $realtobits(27.5));
        chk("order1", popped[1][63:0], $realtobits(11.0));
        chk("order2", popped[2][63:0], $realtobits(1239.5));
        chk("order3", popped[3][63:0], $realtobits(2.0));
        for (int k = 4; k < 9; k++) chk($sformatf("order%0d", k), popped[k][63:0], vals[k]);
        chk("frames_after_fill", 64'(frames_out), 64'd4);

        // Continuous streaming: occupancy pinned at 1, no bubbles.
        popped.delete();
        sent.delete();
        for (int i = 0; i < 100; i++) begin
            logic [63:0] d;
            logic        l;
            d = {$urandom, $urandom};
            l = 1'($urandom_range(0, 1));
            sent.push_back({l, d});
            cycle(1'b0, 1'b1, d, l, 1'b1, 1'b1);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_tvalid", 64'(m_out.TVALID), 64'd1);
        end
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("stream_size", 64'(popped.size()), 64'd100);
        for (int i = 0; i < 100 && i < popped.size(); i++)
            chk("stream_data", popped[i][63:0], sent[i][63:0]);

        // Reset in mid-operation discards queued beats and the frame count.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_count", 64'(count), 64'd5);
        cycle(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_frames", 64'(frames_out), 64'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
            chk("post_rst_tvalid", 64'(m_out.TVALID), 64'd0);
            model_check();
            advance();
        end

        // Frame counter wrap.
        for (int i = 0; i < 70000 && mframes != 16'hFFFF; i++)
            cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("wrap_pre", 64'(frames_out), 64'hFFFF);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("wrap_zero", 64'(frames_out), 64'd0);
        cycle(1'b0, 1'b1, 64'h1234, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("nolast_pop", 64'(frames_out), 64'd0);
        chk("nolast_empty", 64'(empty), 64'd1);

        // Randomised traffic against the queue model, alternating stall-heavy and drain-heavy phases.
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic v;
            logic rd;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
            cycle(r, v, {$urandom, $urandom}, 1'($urandom_range(0, 1)), rd, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
